alu_serial_ctrl: RTL and testbench
==================================

# alu_serial_ctrl

Bit-serial ALU sequencer that drives the team's existing 1-bit ALU slice. It decodes a 4-bit ALU control code into slice controls (A_invert, B_invert, operation, cin), then streams WIDTH operand bits LSB-first through one slice over WIDTH cycles. It collects the result bits and returns a full word with zero, carry and overflow flags. It sits between the CPU's ALU-control path and the register-file writeback, as the area-minimal alternative to the ripple-chain ALU.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  request; accepted only when ready_o=1
- ctrl_i  in  4  ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- src1_i  in  WIDTH  operand A, sampled on accepted start
- src2_i  in  WIDTH  operand B, sampled on accepted start
- ready_o  out  1  high in IDLE
- done_o  out  1  one-cycle pulse, result/flags valid
- result_o  out  WIDTH  registered result, held until next completion
- zero_o  out  1  result_o == 0
- cout_o  out  1  carry out of MSB (ADD/SUB/SLT), else 0
- overflow_o  out  1  signed overflow (ADD/SUB), else 0

## Operation
- States: IDLE → RUN → FINISH → IDLE.
- IDLE: ready_o=1. start_i=1 latches src1_i, src2_i, and the decoded controls; clears bit counter and result shift register; loads the carry flop with the initial cin; goes to RUN.
- Decode:
  - AND: inv 0/0, op 00, cin 0.
  - OR: inv 0/0, op 01, cin 0.
  - ADD: inv 0/0, op 10, cin 0.
  - SUB: A_inv 0, B_inv 1, op 10, cin 1.
  - SLT: same as SUB.
  - NOR: inv 1/1, op 00, cin 0.
  - Undefined code: AND controls with an "invalid" flag; final result forced to 0, flags 0.
- SLT streams as SUB; the slice never uses op 11 because the sign is unknown until the MSB.
- RUN: each cycle, slice inputs are A[idx], B[idx], and the carry flop. Slice result shifts into the result register MSB side (LSB-first fill). The carry flop takes the slice cout. The carry entering the MSB is captured at idx=WIDTH-1. The counter runs 0..WIDTH-1; after idx=WIDTH-1, go to FINISH.
- FINISH: forms result_o and flags, pulses done_o, returns to IDLE.
  - overflow = carry-into-MSB ^ carry-out-MSB (ADD/SUB only).
  - SLT result = {WIDTH-1 zeros, sum_MSB ^ overflow}, i.e. a signed compare. SLT sets cout_o to the carry and overflow_o=0.
  - zero_o is computed from the final result_o.
- start_i while not ready_o is ignored, with no queueing.
- Reset (any time, including mid-RUN): state IDLE, counter 0, carry 0, result_o 0, zero_o 0, cout_o 0, overflow_o 0, done_o 0, ready_o 1. An aborted operation produces no done_o.

## Timing
- Start accepted at edge T0; RUN occupies edges T1..T_WIDTH.
- done_o is high in the cycle after edge T_{WIDTH+1}, i.e. latency WIDTH+1 cycles from acceptance to done. Throughput is one op per WIDTH+2 cycles.
- ready_o goes low the cycle after acceptance and returns high together with done_o. A new start in the done_o cycle is accepted.
- result_o and the flags update only on the FINISH edge and are stable otherwise.
- The counter is $clog2(WIDTH) bits. Terminal detection is idx==WIDTH-1, with no wrap.

## Structure
- Shared package: ALU control code constants (AND/OR/ADD/SUB/SLT/NOR), slice operation encodings (00/01/10/11), and FSM state encoding (2 bits).
- One sub-module: the team's 1-bit slice alu_top, instantiated once with less tied to 0.
- The decoder is combinational inside this block.
- Everything else is local registers: operand shift registers or an index mux, the carry flop, the MSB carry-in flop, and the result shift register.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow 1, cout 0, zero 0; done exactly 33 cycles after start.
- SUB 0x00000005 − 0x00000005 → result 0, zero 1, cout 1, overflow 0.
- SLT 0xFFFFFFFF vs 0x00000001 → 1. SLT 0x7FFFFFFF vs 0x80000000 → 0 (overflow-corrected).
- NOR 0x00000000, 0x00000000 → 0xFFFFFFFF. AND 0xF0F0F0F0 & 0xFF00FF00 → 0xF000F000. OR of the same operands → 0xFFF0FFF0. ctrl 1111 → result 0, done pulses.
- Second start_i during RUN is ignored and the first result is unchanged. Start in the done_o cycle is accepted, with back-to-back results correct.
- Assert rst_i at bit 10 of an ADD → all outputs 0 immediately, no done_o. Next op after release completes correctly.

Source files
------------

// File: rtl/alu_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
// Contents:
//   - ALU control codes as presented by the CPU's ALU-control path
//   - 1-bit slice operation encodings
//   - sequencer FSM state encoding
//   - decode of a control code into slice controls plus result-shaping hints
package alu_serial_ctrl_pkg;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FINISH = 2'b10
  } state_t;

  // Slice controls plus how the final word and flags are to be formed.
  typedef struct packed {
    logic       a_inv;
    logic       b_inv;
    logic [1:0] op;
    logic       cin;
    logic       arith;    // ADD/SUB: report carry and overflow
    logic       slt;      // SLT: reduce the difference to a signed compare
    logic       invalid;  // unknown code: force result and flags to zero
  } ctrl_dec_t;

  function automatic ctrl_dec_t decode_ctrl(input logic [3:0] code);
    ctrl_dec_t d;
    d.a_inv   = 1'b0;
    d.b_inv   = 1'b0;
    d.op      = OP_AND;
    d.cin     = 1'b0;
    d.arith   = 1'b0;
    d.slt     = 1'b0;
    d.invalid = 1'b0;
    case (code)
      CTRL_AND: d.op = OP_AND;
      CTRL_OR:  d.op = OP_OR;
      CTRL_ADD: begin
        d.op    = OP_ADD;
        d.arith = 1'b1;
      end
      CTRL_SUB: begin
        d.b_inv = 1'b1;
        d.op    = OP_ADD;
        d.cin   = 1'b1;
        d.arith = 1'b1;
      end
      // SLT is streamed as a subtraction; the sign is only known at the MSB.
      CTRL_SLT: begin
        d.b_inv = 1'b1;
        d.op    = OP_ADD;
        d.cin   = 1'b1;
        d.slt   = 1'b1;
      end
      CTRL_NOR: begin
        d.a_inv = 1'b1;
        d.b_inv = 1'b1;
        d.op    = OP_AND;
      end
      default: d.invalid = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_top.sv
// One-bit ALU slice.
// Ports:
//   a, b        operand bits
//   a_invert    invert a before use
//   b_invert    invert b before use
//   cin         carry in
//   less        value passed through for the "less" operation
//   operation   00 AND, 01 OR, 10 sum, 11 less
//   result      selected output bit
//   cout        full-adder carry out of the (possibly inverted) operands
module alu_top
  import alu_serial_ctrl_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic       cin,
  input  logic       less,
  input  logic [1:0] operation,
  output logic       result,
  output logic       cout
);

  logic a_eff_s;
  logic b_eff_s;
  logic sum_s;

  // Operand conditioning, full adder and output select.
  always_comb begin
    a_eff_s = a ^ a_invert;
    b_eff_s = b ^ b_invert;
    sum_s   = a_eff_s ^ b_eff_s ^ cin;
    cout    = (a_eff_s & b_eff_s) | (a_eff_s & cin) | (b_eff_s & cin);
    case (operation)
      OP_AND:  result = a_eff_s & b_eff_s;
      OP_OR:   result = a_eff_s | b_eff_s;
      OP_ADD:  result = sum_s;
      OP_LESS: result = less;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: streams WIDTH operand bits LSB-first through a
// single 1-bit slice and returns the full word with zero/carry/overflow.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   start_i, ctrl_i      request and 4-bit ALU control (taken only when ready_o)
//   src1_i, src2_i       operands A and B, sampled on an accepted start
//   ready_o              high while idle
//   done_o               one-cycle pulse when result/flags are updated
//   result_o             result word, held until the next completion
//   zero_o, cout_o, overflow_o   flags belonging to result_o
module alu_serial_ctrl
  import alu_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
)
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  ctrl_dec_t        dec_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_sh_r;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic             cin_msb_r;
  logic             a_inv_r;
  logic             b_inv_r;
  logic [1:0]       op_r;
  logic             arith_r;
  logic             slt_r;
  logic             invalid_r;
  logic             accept_s;
  logic             last_bit_s;
  logic             slice_res_s;
  logic             slice_cout_s;
  logic             ovf_s;
  logic [WIDTH-1:0] result_nxt_s;
  logic             cout_nxt_s;
  logic             ovf_nxt_s;

  assign dec_s      = decode_ctrl(ctrl_i);
  assign ready_o    = (state_r == ST_IDLE);
  assign accept_s   = (state_r == ST_IDLE) && start_i;
  assign last_bit_s = (idx_r == IDX_LAST);
  // Overflow: carry into the MSB differs from carry out of it.
  assign ovf_s      = cin_msb_r ^ carry_r;

  alu_top u_slice (
    .a         (a_sh_r[0]),
    .b         (b_sh_r[0]),
    .a_invert  (a_inv_r),
    .b_invert  (b_inv_r),
    .cin       (carry_r),
    .less      (1'b0),
    .operation (op_r),
    .result    (slice_res_s),
    .cout      (slice_cout_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_bit_s) begin
          state_nxt_s = ST_FINISH;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FINISH: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Final word and flags formed from the collected bits and the carry flops.
  always_comb begin
    result_nxt_s = res_sh_r;
    cout_nxt_s   = 1'b0;
    ovf_nxt_s    = 1'b0;
    if (invalid_r) begin
      result_nxt_s = {WIDTH{1'b0}};
    end else if (slt_r) begin
      // Sign of the overflow-corrected difference gives a signed compare.
      result_nxt_s = {{(WIDTH-1){1'b0}}, res_sh_r[WIDTH-1] ^ ovf_s};
      cout_nxt_s   = carry_r;
    end else if (arith_r) begin
      cout_nxt_s = carry_r;
      ovf_nxt_s  = ovf_s;
    end else begin
      result_nxt_s = res_sh_r;
    end
  end

  // Operand/result shift registers, carry flops and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_sh_r     <= {WIDTH{1'b0}};
      b_sh_r     <= {WIDTH{1'b0}};
      res_sh_r   <= {WIDTH{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      carry_r    <= 1'b0;
      cin_msb_r  <= 1'b0;
      a_inv_r    <= 1'b0;
      b_inv_r    <= 1'b0;
      op_r       <= OP_AND;
      arith_r    <= 1'b0;
      slt_r      <= 1'b0;
      invalid_r  <= 1'b0;
      done_o     <= 1'b0;
      result_o   <= {WIDTH{1'b0}};
      zero_o     <= 1'b0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_sh_r    <= src1_i;
            b_sh_r    <= src2_i;
            res_sh_r  <= {WIDTH{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            carry_r   <= dec_s.cin;
            cin_msb_r <= 1'b0;
            a_inv_r   <= dec_s.a_inv;
            b_inv_r   <= dec_s.b_inv;
            op_r      <= dec_s.op;
            arith_r   <= dec_s.arith;
            slt_r     <= dec_s.slt;
            invalid_r <= dec_s.invalid;
          end else begin
            idx_r <= idx_r;
          end
        end
        ST_RUN: begin
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          res_sh_r <= {slice_res_s, res_sh_r[WIDTH-1:1]};
          carry_r  <= slice_cout_s;
          if (last_bit_s) begin
            // carry_r still holds the carry entering the MSB at this edge.
            cin_msb_r <= carry_r;
            idx_r     <= {IDX_W{1'b0}};
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        ST_FINISH: begin
          result_o   <= result_nxt_s;
          zero_o     <= (result_nxt_s == {WIDTH{1'b0}});
          cout_o     <= cout_nxt_s;
          overflow_o <= ovf_nxt_s;
          done_o     <= 1'b1;
        end
        default: begin
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (WIDTH=32): directed vector table,
// randomized operations against an arithmetic reference model, and
// multi-cycle sequences (ignored start, back-to-back, reset mid-run).
module tb_alu_serial_ctrl;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   ctrl = 4'b0000;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic         ready, done, zero, cout, ovf;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ctrl_i(ctrl),
    .src1_i(src1), .src2_i(src2), .ready_o(ready), .done_o(done),
    .result_o(result), .zero_o(zero), .cout_o(cout), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         v;
  } res_t;

  typedef struct {
    string        name;
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         v;
  } vec_t;

  // Reference: word-level arithmetic straight from the operation definitions.
  function automatic res_t model(input logic [3:0] c, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    res_t m;
    logic [W:0] s;
    m = '0;
    case (c)
      4'b0000: m.r = a & b;
      4'b0001: m.r = a | b;
      4'b1100: m.r = ~(a | b);
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b};
        m.r = s[W-1:0];
        m.c = s[W];
        m.v = (a[W-1] == b[W-1]) && (m.r[W-1] != a[W-1]);
      end
      4'b0110: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        m.r = s[W-1:0];
        m.c = s[W];
        m.v = (a[W-1] != b[W-1]) && (m.r[W-1] != a[W-1]);
      end
      4'b0111: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        m.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        m.c = s[W];
      end
      default: m.r = '0;
    endcase
    m.z = (m.r == '0);
    return m;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [W-1:0] r,
                             input logic z, input logic c, input logic v);
    chk({tag, "_result"}, result, r);
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, z});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, c});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, v});
  endtask

  // Called at a negedge; drives a start for one edge and returns at the next negedge.
  task automatic launch(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    ctrl = c; src1 = a; src2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges until done_o is seen, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_checked(input string tag, input logic [3:0] c,
                             input logic [W-1:0] a, input logic [W-1:0] b);
    res_t m;
    int   lat;
    m = model(c, a, b);
    launch(c, a, b);
    wait_done(lat);
    chk({tag, "_latency"}, lat, LAT);
    chk_outputs(tag, m.r, m.z, m.c, m.v);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    vec_t         vecs[10];
    logic [3:0]   codes[7];
    int           lat, lat2, dones;
    res_t         m;

    vecs[0] = '{"add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{"sub_eq",   4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{"slt_neg",  4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{"slt_ovf",  4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"nor_zero", 4'b1100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"and",      4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"or",       4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{"invalid",  4'b1111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{"sub_borrow", 4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{"sub_ovf",  4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1};
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1010};

    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk_outputs("reset", 32'd0, 1'b0, 1'b0, 1'b0);

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      chk({vecs[i].name, "_ready"}, {31'd0, ready}, 32'd1);
      launch(vecs[i].ctrl, vecs[i].a, vecs[i].b);
      chk({vecs[i].name, "_busy"}, {31'd0, ready}, 32'd0);
      wait_done(lat);
      chk({vecs[i].name, "_latency"}, lat, LAT);
      chk({vecs[i].name, "_ready_at_done"}, {31'd0, ready}, 32'd1);
      chk_outputs(vecs[i].name, vecs[i].r, vecs[i].z, vecs[i].c, vecs[i].v);
      @(negedge clk);
      chk({vecs[i].name, "_done_pulse"}, {31'd0, done}, 32'd0);
      chk({vecs[i].name, "_hold"}, result, vecs[i].r);
    end

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      run_checked("rand", codes[$urandom_range(0, 6)], pick_operand(), pick_operand());
      @(negedge clk);
    end

    // Start during RUN is ignored and nothing is queued.
    launch(4'b0010, 32'd1, 32'd2);
    repeat (5) @(negedge clk);
    start = 1'b1; ctrl = 4'b0110; src1 = 32'd100; src2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("ignored_latency", lat + 6, LAT);
    chk_outputs("ignored", 32'd3, 1'b0, 1'b0, 1'b0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("ignored_no_extra_done", dones, 0);
    chk("ignored_hold", result, 32'd3);

    // Back-to-back: new start issued in the done_o cycle.
    launch(4'b0010, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done(lat);
    chk("b2b_first_latency", lat, LAT);
    chk_outputs("b2b_first", 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    m = model(4'b0110, 32'h1234_5678, 32'h8765_4321);
    launch(4'b0110, 32'h1234_5678, 32'h8765_4321);
    chk("b2b_busy", {31'd0, ready}, 32'd0);
    wait_done(lat2);
    chk("b2b_second_latency", lat2, LAT);
    chk_outputs("b2b_second", m.r, m.z, m.c, m.v);
    @(negedge clk);

    // Reset in the middle of an ADD (after bit 10 has been processed).
    launch(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk_outputs("abort", 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    run_checked("after_abort", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
